// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares a single-port 256x16 memory between the instruction-fetch
//            and load/store units. LS has priority; a starvation guard keeps IF moving.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 12,
    parameter int DATA_W       = 16,
    parameter int MEM_WORDS    = 256,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              err,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    // One extra bit so MEM_WORDS == 2**ADDR_W still compares correctly.
    localparam logic [ADDR_W:0] C_MEM_LIMIT    = (ADDR_W+1)'(MEM_WORDS);
    localparam logic [3:0]      C_STARVE_LIMIT = 4'(STARVE_LIMIT);

    logic [1:0]        r_state;
    logic              r_win_ls;
    logic              r_we;
    logic              r_oor;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_if_rdata;
    logic [DATA_W-1:0] r_ls_rdata;
    logic [3:0]        r_starve_cnt;

    logic              w_grant_if;
    logic              w_grant_ls;
    logic [ADDR_W-1:0] w_sel_addr;
    logic              w_in_access;
    logic              w_in_done;
    logic [DATA_W-1:0] w_rd_data;

    assign w_grant_if  = if_req & (~ls_req | (r_starve_cnt == C_STARVE_LIMIT));
    assign w_grant_ls  = ls_req & ~w_grant_if;
    assign w_sel_addr  = w_grant_ls ? ls_addr : if_addr;
    assign w_in_access = (r_state == S_ACCESS);
    assign w_in_done   = (r_state == S_DONE);
    assign w_rd_data   = r_oor ? '0 : mem_data_out;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_win_ls     <= 1'b0;
            r_we         <= 1'b0;
            r_oor        <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_if_rdata   <= '0;
            r_ls_rdata   <= '0;
            r_starve_cnt <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (if_req | ls_req) begin
                        r_state  <= S_ACCESS;
                        r_win_ls <= w_grant_ls;
                        r_addr   <= w_sel_addr;
                        r_we     <= w_grant_ls & ls_we;
                        r_wdata  <= w_grant_ls ? ls_wdata : '0;
                        r_oor    <= ({1'b0, w_sel_addr} >= C_MEM_LIMIT);
                    end
                    // Counts only IF losses to LS; any other IDLE outcome resets it.
                    if (if_req && w_grant_ls) begin
                        if (r_starve_cnt != 4'hF) begin
                            r_starve_cnt <= r_starve_cnt + 4'd1;
                        end
                    end else begin
                        r_starve_cnt <= '0;
                    end
                end
                S_ACCESS: begin
                    r_state <= S_DONE;
                    if (!r_win_ls) begin
                        r_if_rdata <= w_rd_data;
                    end else if (!r_we) begin
                        r_ls_rdata <= w_rd_data;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Memory-side signals are gated by state so an async reset kills them at once.
    assign mem_address      = w_in_access ? r_addr : '0;
    assign mem_data_in      = w_in_access ? r_wdata : '0;
    assign mem_write_enable = w_in_access & ~r_oor & r_we;
    assign mem_read_enable  = w_in_access & ~r_oor & ~r_we;

    assign if_ack   = w_in_done & ~r_win_ls;
    assign ls_ack   = w_in_done & r_win_ls;
    assign err      = w_in_done & r_oor;
    assign busy     = (r_state != S_IDLE);
    assign if_rdata = r_if_rdata;
    assign ls_rdata = r_ls_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Directed and randomized checks of mem_port_arbiter against a
//            transaction-level model of arbitration and memory contents.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 12;
    localparam int DATA_W       = 16;
    localparam int MEM_WORDS    = 256;
    localparam int STARVE_LIMIT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_ack;
    logic [DATA_W-1:0] if_rdata;
    logic              ls_req = 1'b0;
    logic              ls_we = 1'b0;
    logic [ADDR_W-1:0] ls_addr = '0;
    logic [DATA_W-1:0] ls_wdata = '0;
    logic              ls_ack;
    logic [DATA_W-1:0] ls_rdata;
    logic              err;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic [DATA_W-1:0] mem_data_in;
    logic              mem_write_enable;
    logic              mem_read_enable;
    logic [DATA_W-1:0] mem_data_out;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_WORDS(MEM_WORDS), .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata), .err(err), .busy(busy),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_data_out(mem_data_out)
    );

    // Physical memory: async read, sync write; a preload port fills it under reset.
    logic [DATA_W-1:0] phys [0:MEM_WORDS-1];
    logic              init_we = 1'b0;
    logic [7:0]        init_addr = '0;
    logic [DATA_W-1:0] init_data = '0;

    always @(posedge clk) begin
        if (init_we) phys[init_addr] <= init_data;
        else if (mem_write_enable) phys[mem_address[7:0]] <= mem_data_in;
    end
    assign mem_data_out = phys[mem_address[7:0]];

    // Reference model state
    logic [DATA_W-1:0] ref_mem [0:MEM_WORDS-1];
    int                starve = 0;
    logic [DATA_W-1:0] exp_if_rdata = '0;
    logic [DATA_W-1:0] exp_ls_rdata = '0;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [ADDR_W-1:0] rand_addr();
        if ($urandom_range(0, 7) == 0) return 12'($urandom_range(MEM_WORDS, 4095));
        return 12'($urandom_range(0, MEM_WORDS-1));
    endfunction

    // Entered just after a falling edge with the DUT idle; returns at the next idle falling edge.
    task automatic do_slot(input logic ir, input logic [ADDR_W-1:0] ia, input logic lr,
                           input logic lw, input logic [ADDR_W-1:0] la,
                           input logic [DATA_W-1:0] lwd, output logic [1:0] seen);
        int                win;
        logic [ADDR_W-1:0] a;
        logic              we;
        logic              oor;
        logic [DATA_W-1:0] rd;
        seen = 2'b00;
        chk("idle_busy", busy, 0);
        chk("idle_acks", {if_ack, ls_ack, err}, 0);
        if_req = ir; if_addr = ia; ls_req = lr; ls_we = lw; ls_addr = la; ls_wdata = lwd;
        if (!ir && !lr) win = 0;
        else if (lr && !(ir && starve == STARVE_LIMIT)) win = 2;
        else win = 1;
        if (ir && win == 2) starve = (starve < 15) ? starve + 1 : 15;
        else starve = 0;
        @(posedge clk); @(negedge clk);
        if (win == 0) begin
            chk("noreq_busy", busy, 0);
            chk("noreq_strobes", {mem_write_enable, mem_read_enable}, 0);
            return;
        end
        a   = (win == 1) ? ia : la;
        we  = (win == 2) && lw;
        oor = (a >= MEM_WORDS);
        chk("acc_busy", busy, 1);
        chk("acc_addr", mem_address, a);
        chk("acc_we", mem_write_enable, we && !oor);
        chk("acc_re", mem_read_enable, !we && !oor);
        chk("acc_acks", {if_ack, ls_ack, err}, 0);
        if (we) chk("acc_wdata", mem_data_in, lwd);
        rd = oor ? '0 : ref_mem[a[7:0]];
        if (we && !oor) ref_mem[a[7:0]] = lwd;
        if (win == 1) exp_if_rdata = rd;
        else if (!we) exp_ls_rdata = rd;
        // Address/data may change once the grant has been taken.
        if_addr = rand_addr(); ls_addr = rand_addr(); ls_wdata = 16'($urandom);
        @(posedge clk); @(negedge clk);
        chk("done_if_ack", if_ack, win == 1);
        chk("done_ls_ack", ls_ack, win == 2);
        chk("done_err", err, oor);
        chk("done_if_rdata", if_rdata, exp_if_rdata);
        chk("done_ls_rdata", ls_rdata, exp_ls_rdata);
        chk("done_mem_idle", {mem_write_enable, mem_read_enable, mem_address, mem_data_in}, 0);
        seen = {ls_ack, if_ack};
        @(posedge clk); @(negedge clk);
    endtask

    initial begin
        logic [1:0]        seen;
        logic              ir, lr, lw;
        logic [ADDR_W-1:0] ia, la;
        logic [DATA_W-1:0] lwd;
        logic              hold_if, hold_ls;

        for (int i = 0; i < MEM_WORDS; i++) begin
            @(negedge clk);
            init_we   = 1'b1;
            init_addr = i[7:0];
            init_data = (i == 16) ? 16'hBEEF : 16'($urandom);
            ref_mem[i] = init_data;
        end
        @(negedge clk);
        init_we = 1'b0;

        chk("rst_outputs", {if_ack, ls_ack, err, busy, mem_write_enable, mem_read_enable}, 0);
        chk("rst_mem_bus", {mem_address, mem_data_in}, 0);
        chk("rst_rdata", {if_rdata, ls_rdata}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        do_slot(0, 0, 1, 0, 12'h010, 16'h0, seen);
        chk("load_beef", ls_rdata, 16'hBEEF);
        do_slot(0, 0, 1, 1, 12'h0FF, 16'h1234, seen);
        do_slot(0, 0, 1, 0, 12'h0FF, 16'h0, seen);
        chk("store_then_load", ls_rdata, 16'h1234);
        do_slot(1, 12'h100, 0, 0, 0, 16'h0, seen);
        chk("oor_if_ack_seen", seen, 2'b01);
        chk("oor_if_rdata", if_rdata, 0);

        do_slot(1, 12'h001, 0, 0, 0, 16'h0, seen);
        for (int k = 0; k < 10; k++) begin
            do_slot(1, 12'($urandom_range(0, 255)), 1, 1'($urandom), 12'($urandom_range(0, 255)),
                    16'($urandom), seen);
            chk("starve_order", seen, (k % 5 == 4) ? 2'b01 : 2'b10);
        end

        // Reset during a store's ACCESS with starvation count at 3.
        do_slot(1, 12'h002, 0, 0, 0, 16'h0, seen);
        for (int k = 0; k < 3; k++) do_slot(1, 12'h003, 1, 0, 12'h004, 16'h0, seen);
        if_req = 1; if_addr = 12'h005; ls_req = 1; ls_we = 1; ls_addr = 12'h020; ls_wdata = 16'hA5A5;
        @(posedge clk); @(negedge clk);
        chk("rst_pre_we", mem_write_enable, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_we_drop", mem_write_enable, 0);
        chk("rst_busy_drop", busy, 0);
        chk("rst_addr_drop", mem_address, 0);
        @(posedge clk); @(negedge clk);
        chk("rst_no_ack", {if_ack, ls_ack, err}, 0);
        chk("rst_rdata_clr", {if_rdata, ls_rdata}, 0);
        rst_n = 1'b1;
        starve = 0; exp_if_rdata = '0; exp_ls_rdata = '0;
        do_slot(1, 12'h005, 1, 0, 12'h020, 16'h0, seen);
        chk("rst_cnt_cleared", seen, 2'b10);
        do_slot(1, 12'h005, 0, 0, 0, 16'h0, seen);
        chk("rst_if_grant", seen, 2'b01);

        hold_if = 0; hold_ls = 0; ia = '0; la = '0; lw = 0; lwd = '0;
        for (int t = 0; t < 200; t++) begin
            ir = hold_if ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!hold_if) ia = rand_addr();
            lr = hold_ls ? 1'b1 : ($urandom_range(0, 3) != 0);
            if (!hold_ls) begin
                lw = 1'($urandom); la = rand_addr(); lwd = 16'($urandom);
            end
            do_slot(ir, ia, lr, lw, la, lwd, seen);
            hold_if = ir && !seen[0];
            hold_ls = lr && !seen[1];
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
